// File: rtl/srt2_control_unit.sv
// Moore control FSM for the 8-bit SRT radix-2 divider: drives c[13:0], busy and done.
// Optional divide-by-zero abort is enabled by defining SRT2_CU_DIV0_EN (adds err output).
module srt2_control_unit #(
  parameter int ITER = 8
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        start,
  input  logic        cnt1,
  input  logic [2:0]  cnt2,
  input  logic        m7,
  input  logic [2:0]  ctrl_bits,
  output logic [13:0] c,
  output logic        busy,
`ifdef SRT2_CU_DIV0_EN
  output logic        err,
`endif
  output logic        done
);

  // ITER=8 truncates to 0, matching the datapath counter wrapping after 8 increments.
  localparam logic [2:0] ITER_CNT = 3'(ITER);

  typedef enum logic [4:0] {
    S_IDLE, S_LOAD1, S_LOAD2, S_NORM, S_NORM_CHK, S_SELECT, S_SHIFT, S_ADDSUB,
    S_COUNT, S_CNT_CHK, S_CORR_CHK, S_CORRECT, S_FINAL, S_DENORM, S_OUT1, S_OUT2,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {DIG_ZERO, DIG_POS, DIG_NEG} digit_t;

  state_t state_q, state_d;
  digit_t digit_q, digit_d;

`ifdef SRT2_CU_DIV0_EN
  logic err_q, err_d;
`else
  logic unused_m7;
  assign unused_m7 = m7;
`endif

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q <= S_IDLE;
      digit_q <= DIG_ZERO;
`ifdef SRT2_CU_DIV0_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
`ifdef SRT2_CU_DIV0_EN
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
`ifdef SRT2_CU_DIV0_EN
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD1;
`ifdef SRT2_CU_DIV0_EN
          err_d   = 1'b0;
`endif
        end
      end
      S_LOAD1:    state_d = S_LOAD2;
      S_LOAD2:    state_d = S_NORM;
      S_NORM:     state_d = S_NORM_CHK;
      S_NORM_CHK: begin
        state_d = S_SELECT;
`ifdef SRT2_CU_DIV0_EN
        if (!m7) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
`endif
      end
      S_SELECT: begin
        case (ctrl_bits)
          3'b001, 3'b010, 3'b011: digit_d = DIG_POS;
          3'b100, 3'b101, 3'b110: digit_d = DIG_NEG;
          default:                digit_d = DIG_ZERO;
        endcase
        state_d = S_SHIFT;
      end
      S_SHIFT:    state_d = (digit_q == DIG_ZERO) ? S_COUNT : S_ADDSUB;
      S_ADDSUB:   state_d = S_COUNT;
      S_COUNT:    state_d = S_CNT_CHK;
      S_CNT_CHK:  state_d = (cnt2 == ITER_CNT) ? S_CORR_CHK : S_SELECT;
      S_CORR_CHK: state_d = ctrl_bits[2] ? S_CORRECT : S_FINAL;
      S_CORRECT:  state_d = S_FINAL;
      S_FINAL:    state_d = cnt1 ? S_DENORM : S_OUT1;
      S_DENORM:   state_d = S_OUT1;
      S_OUT1:     state_d = S_OUT2;
      S_OUT2:     state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    c    = '0;
    busy = 1'b1;
    done = 1'b0;
    case (state_q)
      S_IDLE:    busy = 1'b0;
      S_LOAD1:   c[0] = 1'b1;
      S_LOAD2:   c[1] = 1'b1;
      S_NORM:    c[2] = 1'b1;
      S_SHIFT: begin
        c[3] = 1'b1;
        c[4] = (digit_q == DIG_POS);
        c[5] = (digit_q == DIG_NEG);
      end
      S_ADDSUB: begin
        c[6] = 1'b1;
        c[7] = (digit_q == DIG_POS);
      end
      S_COUNT:   c[8]  = 1'b1;
      S_CORRECT: c[9]  = 1'b1;
      S_FINAL:   c[10] = 1'b1;
      S_DENORM:  c[11] = 1'b1;
      S_OUT1:    c[12] = 1'b1;
      S_OUT2:    c[13] = 1'b1;
      S_DONE:    done  = 1'b1;
      default:   ;
    endcase
  end

`ifdef SRT2_CU_DIV0_EN
  assign err = err_q;
`endif

endmodule

// File: tb/tb_srt2_control_unit.sv
// Self-checking bench for srt2_control_unit: randomized and directed divisions compared
// against an expected pulse sequence derived from the digit-selection rules.
module tb_srt2_control_unit;

  localparam int ITER_TB = 8;

  logic        clk = 1'b0;
  logic        rst_b, start, cnt1, m7;
  logic [2:0]  cnt2, ctrl_bits;
  logic [13:0] c;
  logic        busy, done;
`ifdef SRT2_CU_DIV0_EN
  logic        err;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  srt2_control_unit #(.ITER(ITER_TB)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .start     (start),
    .cnt1      (cnt1),
    .cnt2      (cnt2),
    .m7        (m7),
    .ctrl_bits (ctrl_bits),
    .c         (c),
    .busy      (busy),
`ifdef SRT2_CU_DIV0_EN
    .err       (err),
`endif
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Quotient digit from the top three remainder bits read as a signed value.
  function automatic int ref_digit(input logic [2:0] b);
    int v;
    v = int'($signed(b));
    if (v > 0) return 1;
    if (v < -1) return -1;
    return 0;
  endfunction

  function automatic logic [13:0] bitw(input int n);
    logic [13:0] w;
    w = '0;
    w[n] = 1'b1;
    return w;
  endfunction

  // mode: 0 random, 1 all 000, 2 all 010, 3 all 101 + correction + denorm, 4 m7=0
  task automatic run_div(input int mode, input bit noisy_start);
    logic [2:0]  cb [ITER_TB];
    logic        corr, c1, div0;
    logic [13:0] exp_q [$];
    logic [13:0] w;
    int          d, nz, lat, cyc, n_c8;
    bit          seen;

    div0 = 1'b0;
    for (int i = 0; i < ITER_TB; i++) begin
      case (mode)
        1:       cb[i] = 3'b000;
        2:       cb[i] = 3'b010;
        3:       cb[i] = 3'b101;
        default: cb[i] = 3'($urandom_range(0, 7));
      endcase
    end
    corr = (mode == 3) ? 1'b1 : (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    c1   = (mode == 3) ? 1'b1 : (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
`ifdef SRT2_CU_DIV0_EN
    div0 = (mode == 4);
`endif

    exp_q = {};
    exp_q.push_back(bitw(0));
    exp_q.push_back(bitw(1));
    exp_q.push_back(bitw(2));
    nz = 0;
    if (!div0) begin
      for (int i = 0; i < ITER_TB; i++) begin
        d = ref_digit(cb[i]);
        w = bitw(3);
        if (d > 0) w[4] = 1'b1;
        if (d < 0) w[5] = 1'b1;
        exp_q.push_back(w);
        if (d != 0) begin
          w = bitw(6);
          w[7] = (d > 0);
          exp_q.push_back(w);
          nz++;
        end
        exp_q.push_back(bitw(8));
      end
      if (corr) exp_q.push_back(bitw(9));
      exp_q.push_back(bitw(10));
      if (c1) exp_q.push_back(bitw(11));
      exp_q.push_back(bitw(12));
      exp_q.push_back(bitw(13));
      lat = 41 + nz + int'(corr) + int'(c1);
    end else begin
      lat = 5;
    end

    m7        = (mode == 4) ? 1'b0 : 1'b1;
    ctrl_bits = cb[0];
    cnt2      = '0;
    cnt1      = c1;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    n_c8  = 0;
    seen  = 1'b0;
    while (cyc <= 80 && !seen) begin
      if (c != '0) begin
        if (exp_q.size() == 0) check("extra_c", 32'(c), 32'd0);
        else check("c_seq", 32'(c), 32'(exp_q.pop_front()));
      end
      check("busy", 32'(busy), 32'd1);
`ifdef SRT2_CU_DIV0_EN
      check("err", 32'(err), 32'(div0 && done));
`endif
      if (c[8]) begin
        n_c8++;
        cnt2 = cnt2 + 3'd1;
        if (n_c8 < ITER_TB) ctrl_bits = cb[n_c8];
        else ctrl_bits = {corr, 2'($urandom_range(0, 3))};
      end
      if (done) begin
        seen = 1'b1;
        check("latency", 32'(cyc), 32'(lat));
        check("queue_left", 32'(exp_q.size()), 32'd0);
      end else begin
        if (noisy_start) start = 1'($urandom_range(0, 1));
        @(negedge clk);
        cyc++;
      end
    end
    if (!seen) check("timeout", 32'(seen), 32'd1);

    start = noisy_start;
    @(negedge clk);
    start = 1'b0;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_c", 32'(c), 32'd0);
`ifdef SRT2_CU_DIV0_EN
    check("err_hold", 32'(err), 32'(div0));
`endif
    @(negedge clk);
    check("idle2_busy", 32'(busy), 32'd0);
    check("idle2_c", 32'(c), 32'd0);
  endtask

  task automatic reset_mid_shift();
    int n;
    ctrl_bits = 3'b010;
    cnt2      = '0;
    cnt1      = 1'b0;
    m7        = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!c[3] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("reach_shift", 32'(c[3]), 32'd1);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    check("rst_c", 32'(c), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    check("rst_stay_busy", 32'(busy), 32'd0);
    check("rst_stay_c", 32'(c), 32'd0);
  endtask

  initial begin
    rst_b     = 1'b1;
    start     = 1'b0;
    cnt1      = 1'b0;
    cnt2      = '0;
    m7        = 1'b1;
    ctrl_bits = '0;
    repeat (3) @(negedge clk);
    check("reset_c", 32'(c), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
`ifdef SRT2_CU_DIV0_EN
    check("reset_err", 32'(err), 32'd0);
`endif
    rst_b = 1'b0;
    @(negedge clk);
    check("post_reset_busy", 32'(busy), 32'd0);

    run_div(1, 1'b0);
    run_div(2, 1'b0);
    run_div(3, 1'b0);
    reset_mid_shift();
    run_div(1, 1'b0);
    for (int i = 0; i < 8; i++) run_div(0, (i % 2) == 1);
    run_div(3, 1'b1);
    run_div(4, 1'b0);
    run_div(1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
